alu_mp_seq: RTL and testbench
=============================

Name: alu_mp_seq

Overview:
- Multi-precision sequencer for the shared 16-bit ALU (functions: add-with-carry, A AND NOT B, A OR B, NOT B).
- Latches WORDS×16-bit operands on START, then drives the ALU one word per cycle, LSW first, chaining carry.
- Captures each ALU result into a result register and reports carry and zero flags.
- SUB is built from two ALU passes per word: NOT B, then ADD with carry-in.

Parameters:
- WORDS, 4, number of 16-bit words per operand (2..8).

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET_N  in  1  reset; synchronous, active-low.
- START  in  1  request; sampled only in IDLE.
- OP  in  3  operation: 000 ADD, 001 ADC, 010 SUB, 011 ANDN, 100 OR, 101 NOT; 110/111 reserved.
- CI  in  1  carry-in for ADC word 0.
- OPA  in  16*WORDS  operand A; latched when START is accepted.
- OPB  in  16*WORDS  operand B; latched when START is accepted.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  16*WORDS  result register; holds until the next accepted START.
- CARRY  out  1  final carry. For SUB: 1 = no borrow.
- ZERO  out  1  RESULT == 0; valid while DONE is high and held afterwards.
- ALU_A  out  16  ALU A operand.
- ALU_B  out  16  ALU B operand.
- ALU_CIN  out  1  ALU carry-in.
- ALU_FUNC  out  2  00 add, 01 A&~B, 10 A|B, 11 ~B.
- ALU_OUT  in  16  ALU result; combinational from ALU_* outputs.
- ALU_COUT  in  1  ALU carry-out.

Behaviour:
- Reset (RESET_N low at an edge):
  - State goes to IDLE.
  - BUSY, DONE, CARRY and ZERO go to 0; RESULT goes to 0.
  - ALU_A, ALU_B, ALU_CIN go to 0; ALU_FUNC goes to 00.
  - Reset mid-operation aborts with no DONE pulse; BUSY is 0 in the cycle after the reset edge.
- States: IDLE, INV, EXEC, FIN.
- IDLE:
  - START=1 with a legal OP: latch OPA, OPB, OP; word index i=0; carry register c = CI for ADC, 1 for SUB, else 0.
  - Next state is INV for SUB, EXEC otherwise.
  - Reserved OP: START ignored, stay IDLE.
- INV (SUB only):
  - Drive ALU_FUNC=11, ALU_B=OPB[i].
  - At the edge, capture ALU_OUT into tmpB; go to EXEC.
- EXEC:
  - Drive ALU_A=OPA[i]; ALU_B = tmpB for SUB, OPB[i] otherwise.
  - ALU_FUNC: 00 for ADD/ADC/SUB, 01 for ANDN, 10 for OR, 11 for NOT.
  - ALU_CIN = c for arithmetic ops, 0 for logic ops.
  - At the edge: RESULT[i] <= ALU_OUT; c <= ALU_COUT for arithmetic ops, else 0.
  - If i == WORDS-1, go to FIN; otherwise i++ and return to INV (SUB) or stay in EXEC.
- FIN: DONE=1 for this one cycle, BUSY=0, CARRY=c, ZERO=(RESULT==0); next state IDLE.
- Latency, counted from the START edge:
  - BUSY high for exactly WORDS cycles (2*WORDS for SUB).
  - DONE rises in the following cycle.
- START during BUSY or FIN is ignored (no queueing). The earliest next START is accepted in the cycle after DONE.
- Outside INV/EXEC, the ALU_* outputs hold their idle values: A=B=0, CIN=0, FUNC=00.
- RESULT and flags are stable from DONE until the next accepted START. RESULT words update progressively while BUSY.
- Width rules:
  - Carry is chained word to word; CARRY reports the carry out of the MSW only.
  - No overflow flag.
  - Word i occupies bits [16i+15:16i].

Decomposition:
- Shared package alu_pkg holds:
  - ALU FUNC encodings: FN_ADD, FN_ANDN, FN_OR, FN_NOT.
  - OP encodings.
  - State encoding for alu_mp_seq.
- No sub-module. The ALU is instantiated beside this block at the parent level, with its ports wired to ALU_*.
- Word select: an indexed part-select on the latched operands.

Test Plan (WORDS=4, behavioural ALU model attached):
1. ADD, OPA=0x0000_0000_0000_FFFF, OPB=0x1 -> RESULT 0x0000_0000_0001_0000, CARRY 0, ZERO 0; BUSY exactly 4 cycles; DONE exactly 1 cycle.
2. ADD, OPA=0xFFFF_FFFF_FFFF_FFFF, OPB=0x1 -> RESULT 0, CARRY 1, ZERO 1; ADC with the same operands and CI=1 -> RESULT 0x1, CARRY 1.
3. SUB, OPA=0x5, OPB=0x7 -> RESULT 0xFFFF_FFFF_FFFF_FFFE, CARRY 0. SUB, OPA=0x7, OPB=0x5 -> RESULT 0x2, CARRY 1. Both: BUSY 8 cycles; ALU_FUNC alternates 11/00.
4. ANDN, OPA=0xF0F0_F0F0_F0F0_F0F0, OPB=0xFF00_FF00_FF00_FF00 -> RESULT 0x00F0_00F0_00F0_00F0, CARRY 0. NOT, OPB=0 -> RESULT all-ones.
5. START pulsed mid-ADD with different operands -> ignored; the first result is unchanged. START with OP=110 -> BUSY stays 0.
6. RESET_N low during word 2 of SUB -> next cycle BUSY 0, RESULT 0, ALU_FUNC 00, no DONE. A following ADD 1+1 -> RESULT 0x2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-precision ALU sequencer: ALU functions, ops and FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    FnAdd  = 2'b00,
    FnAndn = 2'b01,
    FnOr   = 2'b10,
    FnNot  = 2'b11
  } alu_fn_e;

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpAdc  = 3'b001,
    OpSub  = 3'b010,
    OpAndn = 3'b011,
    OpOr   = 3'b100,
    OpNot  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StInv  = 2'b01,
    StExec = 2'b10,
    StFin  = 2'b11
  } seq_state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= 3'b101;
  endfunction

  function automatic logic op_is_arith(input op_e op);
    return (op == OpAdd) || (op == OpAdc) || (op == OpSub);
  endfunction

  function automatic alu_fn_e op_to_fn(input op_e op);
    case (op)
      OpAndn:  return FnAndn;
      OpOr:    return FnOr;
      OpNot:   return FnNot;
      default: return FnAdd;
    endcase
  endfunction

endpackage

// File: rtl/alu_mp_seq_if.sv
// Request/response bus of the multi-precision sequencer; master issues operations.
interface alu_mp_seq_if #(
  parameter int unsigned Words = 4
);
  logic                  start;
  logic [2:0]            op;
  logic                  ci;
  logic [16*Words-1:0]   opa;
  logic [16*Words-1:0]   opb;
  logic                  busy;
  logic                  done;
  logic [16*Words-1:0]   result;
  logic                  carry;
  logic                  zero;

  modport master (
    output start, op, ci, opa, opb,
    input  busy, done, result, carry, zero
  );

  modport slave (
    input  start, op, ci, opa, opb,
    output busy, done, result, carry, zero
  );
endinterface

// File: rtl/alu_mp_seq.sv
// Drives an external 16-bit ALU one word per cycle (LSW first) to perform Words-wide ops.
// SUB uses two ALU passes per word: invert B, then add with chained carry.
module alu_mp_seq
  import alu_pkg::*;
#(
  parameter int unsigned Words = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  alu_mp_seq_if.slave  bus_io,
  output logic [15:0]  alu_a_o,
  output logic [15:0]  alu_b_o,
  output logic         alu_cin_o,
  output logic [1:0]   alu_func_o,
  input  logic [15:0]  alu_out_i,
  input  logic         alu_cout_i
);

  localparam int unsigned IdxW = $clog2(Words);
  localparam int unsigned W    = 16 * Words;

  seq_state_e      state_q, state_d;
  op_e             op_q, op_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            c_q, c_d;
  logic [15:0]     tmpb_q, tmpb_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;

  logic [15:0]     opa_word, opb_word;
  logic            last_word;

  assign opa_word  = opa_q[{idx_q, 4'd0} +: 16];
  assign opb_word  = opb_q[{idx_q, 4'd0} +: 16];
  assign last_word = (idx_q == IdxW'(Words - 1));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    c_d        = c_q;
    tmpb_d     = tmpb_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    alu_a_o    = '0;
    alu_b_o    = '0;
    alu_cin_o  = 1'b0;
    alu_func_o = FnAdd;

    case (state_q)
      StIdle: begin
        if (bus_io.start && op_is_legal(bus_io.op)) begin
          op_d  = op_e'(bus_io.op);
          opa_d = bus_io.opa;
          opb_d = bus_io.opb;
          idx_d = '0;
          if (op_e'(bus_io.op) == OpAdc) begin
            c_d = bus_io.ci;
          end else begin
            // Two's-complement subtract: the +1 of ~B enters as word-0 carry-in.
            c_d = (op_e'(bus_io.op) == OpSub);
          end
          state_d = (op_e'(bus_io.op) == OpSub) ? StInv : StExec;
        end
      end
      StInv: begin
        alu_func_o = FnNot;
        alu_b_o    = opb_word;
        tmpb_d     = alu_out_i;
        state_d    = StExec;
      end
      StExec: begin
        alu_a_o    = opa_word;
        alu_b_o    = (op_q == OpSub) ? tmpb_q : opb_word;
        alu_func_o = op_to_fn(op_q);
        alu_cin_o  = op_is_arith(op_q) ? c_q : 1'b0;
        result_d[{idx_q, 4'd0} +: 16] = alu_out_i;
        c_d = op_is_arith(op_q) ? alu_cout_i : 1'b0;
        if (last_word) begin
          carry_d = c_d;
          zero_d  = (result_d == '0);
          state_d = StFin;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = (op_q == OpSub) ? StInv : StExec;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      idx_q    <= '0;
      c_q      <= 1'b0;
      tmpb_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      c_q      <= c_d;
      tmpb_q   <= tmpb_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign bus_io.busy   = (state_q == StInv) || (state_q == StExec);
  assign bus_io.done   = (state_q == StFin);
  assign bus_io.result = result_q;
  assign bus_io.carry  = carry_q;
  assign bus_io.zero   = zero_q;

endmodule

// File: tb/tb_alu_mp_seq.sv
// Directed bench for alu_mp_seq with a behavioural 16-bit ALU beside the sequencer.
module tb_alu_mp_seq;

  localparam int unsigned Words = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_cin, alu_cout;
  logic [1:0]  alu_func;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mp_seq_if #(.Words(Words)) bus ();

  alu_mp_seq #(.Words(Words)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus_io     (bus),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_cin_o  (alu_cin),
    .alu_func_o (alu_func),
    .alu_out_i  (alu_out),
    .alu_cout_i (alu_cout)
  );

  always_comb begin
    alu_out  = '0;
    alu_cout = 1'b0;
    case (alu_func)
      2'b00:   {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
      2'b01:   alu_out = alu_a & ~alu_b;
      2'b10:   alu_out = alu_a | alu_b;
      default: alu_out = ~alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        ci;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_r;
    logic        exp_c;
    logic        exp_z;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int  cnt;
    int  exp_cnt;
    bit  alt_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.ci    = v.ci;
    bus.opa   = v.a;
    bus.opb   = v.b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.opa   = ~v.a;
    bus.opb   = ~v.b;
    bus.ci    = ~v.ci;
    cnt     = 0;
    alt_ok  = 1'b1;
    exp_cnt = (v.op == 3'b010) ? 2 * Words : Words;
    while (bus.busy && cnt < 40) begin
      if (v.op == 3'b010 && alu_func !== ((cnt % 2 == 0) ? 2'b11 : 2'b00)) alt_ok = 1'b0;
      cnt++;
      @(negedge clk);
    end
    chk({v.name, " busy_cycles"}, 64'(cnt), 64'(exp_cnt));
    if (v.op == 3'b010) chk({v.name, " func_alternate"}, 64'(alt_ok), 64'd1);
    chk({v.name, " done"}, 64'(bus.done), 64'd1);
    chk({v.name, " result"}, bus.result, v.exp_r);
    chk({v.name, " carry"}, 64'(bus.carry), 64'(v.exp_c));
    chk({v.name, " zero"}, 64'(bus.zero), 64'(v.exp_z));
    @(negedge clk);
    chk({v.name, " done_one_cycle"}, 64'(bus.done), 64'd0);
    chk({v.name, " result_held"}, bus.result, v.exp_r);
    chk({v.name, " alu_idle"}, {46'd0, alu_a, alu_func}, 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"add_c16",  3'b000, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1,
                64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{"add_wrap", 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                64'h0, 1'b1, 1'b1};
    vecs[2] = '{"adc_ci1",  3'b001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                64'h1, 1'b1, 1'b0};
    vecs[3] = '{"sub_neg",  3'b010, 1'b0, 64'h5, 64'h7,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{"sub_pos",  3'b010, 1'b0, 64'h7, 64'h5, 64'h2, 1'b1, 1'b0};
    vecs[5] = '{"andn",     3'b011, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'h00F0_00F0_00F0_00F0, 1'b0, 1'b0};
    vecs[6] = '{"not",      3'b101, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[7] = '{"or",       3'b100, 1'b0, 64'hF000_0000_0000_000F, 64'h0F00_0000_0000_00F0,
                64'hFF00_0000_0000_00FF, 1'b0, 1'b0};
    vecs[8] = '{"adc_ci0",  3'b001, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 64'h1,
                64'h0001_0000_0000_0000, 1'b0, 1'b0};
    vecs[9] = '{"sub_eq",   3'b010, 1'b0, 64'h8000_0000_0000_1234, 64'h8000_0000_0000_1234,
                64'h0, 1'b1, 1'b1};

    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.ci    = 1'b0;
    bus.opa   = '0;
    bus.opb   = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset result", bus.result, 64'd0);
    chk("reset flags", {62'd0, bus.carry, bus.zero}, 64'd0);
    chk("reset alu", {29'd0, alu_a, alu_b, alu_cin, alu_func}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // START pulsed mid-operation must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.opa   = 64'h0000_0000_0000_FFFF;
    bus.opb   = 64'h1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b010;
    bus.opa   = 64'h1111_1111_1111_1111;
    bus.opb   = 64'h2222_2222_2222_2222;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 40 && !bus.done; k++) @(negedge clk);
    chk("midstart done", 64'(bus.done), 64'd1);
    chk("midstart result", bus.result, 64'h0000_0000_0001_0000);
    @(negedge clk);
    chk("midstart no_requeue", 64'(bus.busy), 64'd0);

    // Reserved op code is not accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b110;
    @(negedge clk);
    bus.start = 1'b0;
    chk("reserved busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("reserved done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("reserved result", bus.result, 64'h0000_0000_0001_0000);

    // Reset during word 2 of SUB aborts with no DONE.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b010;
    bus.opa   = 64'h7;
    bus.opb   = 64'h5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort in_inv2", {62'd0, bus.busy, alu_func == 2'b11}, 64'd3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort result", bus.result, 64'd0);
    chk("abort func", 64'(alu_func), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    begin
      bit seen_done;
      seen_done = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (bus.done) seen_done = 1'b1;
      end
      chk("abort no_done_later", 64'(seen_done), 64'd0);
    end
    run_op('{"add_after_rst", 3'b000, 1'b0, 64'h1, 64'h1, 64'h2, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
